// File: rtl/adder_pkg.sv
// Shared types and parameter checks for the chunked adder.
package adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic bit params_legal(int unsigned width, int unsigned chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunked_adder_if.sv
// Operand/result handshake bundle for chunked_adder.
interface chunked_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, carry_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, carry_in, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/ripple_slice.sv
// Combinational CHUNK-bit ripple-carry adder built from per-bit full adders.
module ripple_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_s,
  output logic             o_cout,
  output logic             o_c_msb
);
  logic [CHUNK:0] w_c;

  always_comb begin
    w_c    = '0;
    o_s    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < int'(CHUNK); i++) begin
      o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout  = w_c[CHUNK];
  assign o_c_msb = w_c[CHUNK-1];
endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, carry held in a register.
module chunked_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic           clk,
  input logic           rst,
  chunked_adder_if.slave bus
);
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!params_legal(WIDTH, CHUNK)) begin : g_param_check
    $fatal(1, "chunked_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_carry, r_carry_out, r_overflow;
  logic [IDX_W-1:0] r_idx;
  logic [CHUNK-1:0] w_a_chunk, w_b_chunk, w_s;
  logic             w_cout, w_c_msb, w_accept, w_last;

  assign w_accept  = bus.in_valid && (r_state == StIdle);
  assign w_last    = (r_idx == IDX_W'(NCHUNK - 1));
  assign w_a_chunk = r_a[32'(r_idx) * CHUNK +: CHUNK];
  assign w_b_chunk = r_b[32'(r_idx) * CHUNK +: CHUNK];

  ripple_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .i_a     (w_a_chunk),
    .i_b     (w_b_chunk),
    .i_cin   (r_carry),
    .o_s     (w_s),
    .o_cout  (w_cout),
    .o_c_msb (w_c_msb)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  if (bus.out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Subtraction is folded in at accept time: b is inverted and the carry forced to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_idx       <= '0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.sub ? ~bus.b : bus.b;
      r_carry <= bus.sub | bus.carry_in;
      r_idx   <= '0;
    end else if (r_state == StRun) begin
      r_sum[32'(r_idx) * CHUNK +: CHUNK] <= w_s;
      r_carry <= w_cout;
      r_idx   <= r_idx + IDX_W'(1);
      if (w_last) begin
        r_carry_out <= w_cout;
        r_overflow  <= w_cout ^ w_c_msb;
      end
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = (r_state == StDone);
  assign bus.sum       = r_sum;
  assign bus.carry_out = r_carry_out;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_chunked_adder.sv
// Directed and reference-model checks of chunked_adder at 16/4, 8/8 and 32/8.
module tb_chunked_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  chunked_adder_if #(.WIDTH(16)) bus16 ();
  chunked_adder_if #(.WIDTH(8))  bus8 ();
  chunked_adder_if #(.WIDTH(32)) bus32 ();

  chunked_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  chunked_adder #(.WIDTH(8),  .CHUNK(8)) u_dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  chunked_adder #(.WIDTH(32), .CHUNK(8)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full 16-bit transaction; operands are scrambled during RUN to prove they are ignored.
  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sb, input logic [15:0] es,
                       input logic eco, input logic eov);
    int cyc;
    check({tag, " ready"}, 64'(bus16.in_ready), 64'(1));
    bus16.a = a; bus16.b = b; bus16.carry_in = cin; bus16.sub = sb; bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0; bus16.a = ~a; bus16.b = ~b; bus16.sub = ~sb;
    cyc = 0;
    while (!bus16.out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(4));
    check({tag, " result"}, {46'd0, bus16.carry_out, bus16.overflow, bus16.sum},
          {46'd0, eco, eov, es});
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
    check({tag, " idle"}, {62'd0, bus16.in_ready, bus16.out_valid}, 64'b10);
  endtask

  initial begin
    logic [31:0] ra, rb, rsum;
    logic        rsub, rcin, rbit, rco, rov;
    logic [32:0] full;
    logic [15:0] held;
    bit          stable;
    int          cyc;

    bus16.in_valid = 0; bus16.a = 0; bus16.b = 0; bus16.carry_in = 0; bus16.sub = 0;
    bus16.out_ready = 0;
    bus8.in_valid = 0; bus8.a = 0; bus8.b = 0; bus8.carry_in = 0; bus8.sub = 0;
    bus8.out_ready = 0;
    bus32.in_valid = 0; bus32.a = 0; bus32.b = 0; bus32.carry_in = 0; bus32.sub = 0;
    bus32.out_ready = 0;

    repeat (2) @(posedge clk);
    #1;
    check("reset16", {45'd0, bus16.in_ready, bus16.out_valid, bus16.carry_out,
                      bus16.overflow, bus16.sum}, {45'd0, 4'b1000, 16'h0000});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run16("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run16("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run16("add_cin",   16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    run16("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run16("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run16("sub_zero",  16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Backpressure: hold DONE with a competing request pending.
    bus16.a = 16'h00FF; bus16.b = 16'h0F01; bus16.carry_in = 0; bus16.sub = 0;
    bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.a = 16'hAAAA; bus16.b = 16'h5555;
    cyc = 0;
    while (!bus16.out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp latency", 64'(cyc), 64'(4));
    held = bus16.sum;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus16.sum !== held || !bus16.out_valid || bus16.in_ready) stable = 1'b0;
    end
    check("bp stable", 64'(stable), 64'(1));
    check("bp result", {46'd0, bus16.carry_out, bus16.overflow, bus16.sum},
          {46'd0, 2'b00, 16'h1000});
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0; bus16.in_valid = 1'b0;
    check("bp release", {62'd0, bus16.in_ready, bus16.out_valid}, 64'b10);
    @(posedge clk); #1;
    check("bp no accept", {62'd0, bus16.in_ready, bus16.out_valid}, 64'b10);

    // Reset during RUN, at chunk 2.
    bus16.a = 16'h1111; bus16.b = 16'h2222; bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid reset", {45'd0, bus16.in_ready, bus16.out_valid, bus16.carry_out,
                        bus16.overflow, bus16.sum}, {45'd0, 4'b1000, 16'h0000});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run16("post_rst",  16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

    // Single-chunk configuration: latency 1.
    bus8.a = 8'h80; bus8.b = 8'h80; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    check("w8 latency", 64'(bus8.out_valid), 64'(0));
    @(posedge clk); #1;
    check("w8 valid", 64'(bus8.out_valid), 64'(1));
    check("w8 result", {54'd0, bus8.carry_out, bus8.overflow, bus8.sum},
          {54'd0, 2'b11, 8'h00});
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    check("w8 idle", {62'd0, bus8.in_ready, bus8.out_valid}, 64'b10);

    // Random add/sub at 32/8 against an integer reference.
    bus32.out_ready = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom;
      rsub = 1'($urandom_range(0, 1));
      rcin = 1'($urandom_range(0, 1));
      rbit = rsub ? 1'b1 : rcin;
      full = {1'b0, ra} + {1'b0, (rsub ? ~rb : rb)} + {32'd0, rbit};
      rsum = full[31:0];
      rco  = full[32];
      rov  = (ra[31] == (rsub ? ~rb[31] : rb[31])) && (rsum[31] != ra[31]);
      bus32.a = ra; bus32.b = rb; bus32.sub = rsub; bus32.carry_in = rcin;
      bus32.in_valid = 1'b1;
      @(posedge clk); #1;
      bus32.in_valid = 1'b0;
      cyc = 0;
      while (!bus32.out_valid && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("rnd32", {cyc[29:0], bus32.carry_out, bus32.overflow, bus32.sum},
            {30'd4, rco, rov, rsum});
      bus32.out_ready = 1'b1;
      @(posedge clk); #1;
      bus32.out_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
